// File: rtl/perf_counter_pkg.sv
// Shared constants for the performance counter bank: bus address map
// (before the per-instance offset is added) and LED source selection codes.
package perf_counter_pkg;

  localparam logic [7:0] CTRL         = 8'h00;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] OVF_CLR      = 8'h02;
  localparam logic [7:0] LED_FUNCTION = 8'h03;
  localparam logic [7:0] LED_DIRECT   = 8'h04;
  localparam logic [7:0] CTRL_RD      = 8'h05;
  localparam logic [7:0] OVF_RD       = 8'h06;
  localparam logic [7:0] CNT_BASE     = 8'h20;
  localparam int         CH_STRIDE    = 4;

  typedef enum logic [1:0] {
    LED_DIRECTLY_FROM_DSP = 2'b00,
    LED_FROM_COUNT_CLK    = 2'b01,
    LED_FROM_CH1          = 2'b10,
    LED_SLOW_HEARTBEAT    = 2'b11
  } led_func_e;

endpackage

// File: rtl/perf_counter_channel.sv
// One counter channel: event synchroniser and edge detect, counter with
// wrap/saturate behaviour, sticky overflow flag and a read-coherence shadow.
// The clock channel ignores its event input and counts every enabled cycle.
module perf_counter_channel
  import perf_counter_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter bit IS_CLK_CH = 1'b0
) (
  input  logic                 xclk,
  input  logic                 reset,
  input  logic                 event_in,
  input  logic                 enable,
  input  logic                 sat_mode,
  input  logic                 clear,
  input  logic                 ovf_clr,
  input  logic                 capture,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 ovf
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic sync1, sync2, sync3;
  logic inc, at_max;

  // two-flop synchroniser plus one stage of history for rising-edge detect
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= event_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign at_max = &count;
  // clear wins over an increment in the same cycle
  assign inc = enable & ~clear & (IS_CLK_CH ? 1'b1 : (sync2 & ~sync3));

  // counter: clear, else increment with wrap or hold-at-max in saturate mode
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(at_max && sat_mode)) begin
      count <= count + ONE;
    end
  end

  // sticky overflow: an increment attempted at all-ones beats a clear request
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (inc && at_max) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // shadow takes the pre-increment value on a low-word read
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
    end else if (capture) begin
      shadow <= count;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH performance counters on the 8-bit address / 16-bit data DSP
// bus. Channel 0 counts clock cycles, the others count event_in rising edges.
//
// Bus access semantics: read_qualified / write_qualified may stay high for
// several clocks, but only the first high cycle is an access. Read data and
// data_avail are registered one clock after that first cycle, hold while the
// read strobe stays high, data_avail drops the clock after the strobe falls
// and db_out keeps its last value.
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int CNT_WIDTH           = 32,
  parameter int LED_WIDTH           = 2,
  parameter int HB_BIT              = 26,
  parameter int offset_to_add_to_ab = 0
) (
  input  logic                 xclk,
  input  logic                 reset,
  input  logic                 write_qualified,
  input  logic                 read_qualified,
  input  logic [7:0]           ab,
  input  logic [15:0]          db_in,
  input  logic [NUM_CH-1:0]    event_in,
  output logic [15:0]          db_out,
  output logic                 data_avail,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam int         WORDS          = CNT_WIDTH / 16;
  localparam logic [7:0] OFS            = 8'(offset_to_add_to_ab);
  localparam logic [7:0] A_CTRL         = CTRL + OFS;
  localparam logic [7:0] A_CLEAR        = CLEAR + OFS;
  localparam logic [7:0] A_OVF_CLR      = OVF_CLR + OFS;
  localparam logic [7:0] A_LED_FUNCTION = LED_FUNCTION + OFS;
  localparam logic [7:0] A_LED_DIRECT   = LED_DIRECT + OFS;
  localparam logic [7:0] A_CTRL_RD      = CTRL_RD + OFS;
  localparam logic [7:0] A_OVF_RD       = OVF_RD + OFS;
  localparam logic [7:0] A_CNT_BASE     = CNT_BASE + OFS;

  logic                 read_qualified_d, write_qualified_d;
  logic                 rd_first, wr_first;
  logic [NUM_CH-1:0]    en_mask;
  logic                 sat_mode;
  logic [1:0]           led_function;
  logic [LED_WIDTH-1:0] led_direct;
  logic [LED_WIDTH-1:0] led_next;
  logic [NUM_CH-1:0]    clear_vec, ovf_clr_vec, capture_vec, ovf_vec;
  logic [CNT_WIDTH-1:0] cnt_all [NUM_CH];
  logic [CNT_WIDTH-1:0] shd_all [NUM_CH];
  logic [7:0]           cnt_off;
  logic [5:0]           rd_ch;
  logic [1:0]           rd_word;
  logic                 cnt_hit;
  logic [15:0]          ctrl_word, ovf_word, rd_data;
  logic                 rd_hit;
  logic                 unused_bits;

  // strobe history; reset high so a strobe held across reset is not a new access
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      read_qualified_d  <= 1'b1;
      write_qualified_d <= 1'b1;
    end else begin
      read_qualified_d  <= read_qualified;
      write_qualified_d <= write_qualified;
    end
  end

  assign rd_first = read_qualified & ~read_qualified_d;
  assign wr_first = write_qualified & ~write_qualified_d;

  assign cnt_off = ab - A_CNT_BASE;
  assign rd_ch   = cnt_off[7:2];
  assign rd_word = cnt_off[1:0];
  assign cnt_hit = (cnt_off < 8'(CH_STRIDE * NUM_CH)) && ({30'd0, rd_word} < 32'(WORDS));

  assign clear_vec   = (wr_first && ab == A_CLEAR)   ? db_in[NUM_CH-1:0] : '0;
  assign ovf_clr_vec = (wr_first && ab == A_OVF_CLR) ? db_in[NUM_CH-1:0] : '0;

  assign ctrl_word = {sat_mode, {(15 - NUM_CH){1'b0}}, en_mask};
  assign ovf_word  = {{(16 - NUM_CH){1'b0}}, ovf_vec};
  assign unused_bits = ^db_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic unused_ch;
    assign unused_ch = ^{cnt_all[g], shd_all[g]};
    assign capture_vec[g] = rd_first & cnt_hit & (rd_word == 2'd0) & (rd_ch == 6'(g));

    perf_counter_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .IS_CLK_CH (g == 0)
    ) u_ch (
      .xclk     (xclk),
      .reset    (reset),
      .event_in (event_in[g]),
      .enable   (en_mask[g]),
      .sat_mode (sat_mode),
      .clear    (clear_vec[g]),
      .ovf_clr  (ovf_clr_vec[g]),
      .capture  (capture_vec[g]),
      .count    (cnt_all[g]),
      .shadow   (shd_all[g]),
      .ovf      (ovf_vec[g])
    );
  end

  // control registers written on the first cycle of a write access
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      en_mask      <= '1;
      sat_mode     <= 1'b0;
      led_function <= LED_SLOW_HEARTBEAT;
      led_direct   <= LED_WIDTH'(1);
    end else if (wr_first) begin
      if (ab == A_CTRL) begin
        en_mask  <= db_in[NUM_CH-1:0];
        sat_mode <= db_in[15];
      end
      if (ab == A_LED_FUNCTION) led_function <= db_in[1:0];
      if (ab == A_LED_DIRECT)   led_direct   <= db_in[LED_WIDTH-1:0];
    end
  end

  // read data mux: word 0 is the live low word, upper words come from the shadow
  always_comb begin
    rd_data = 16'hFFFF;
    rd_hit  = 1'b0;
    if (ab == A_CTRL_RD) begin
      rd_data = ctrl_word;
      rd_hit  = 1'b1;
    end else if (ab == A_OVF_RD) begin
      rd_data = ovf_word;
      rd_hit  = 1'b1;
    end else if (cnt_hit) begin
      rd_hit = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch == 6'(c)) begin
          rd_data = cnt_all[c][15:0];
          for (int w = 1; w < WORDS; w++) begin
            if (rd_word == 2'(w)) rd_data = shd_all[c][16*w +: 16];
          end
        end
      end
    end
  end

  // registered read response, held while the strobe stays high
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      db_out     <= 16'h0000;
      data_avail <= 1'b0;
    end else if (rd_first) begin
      db_out     <= rd_data;
      data_avail <= rd_hit;
    end else if (!read_qualified) begin
      data_avail <= 1'b0;
    end
  end

  // LED source selection
  always_comb begin
    led_next = led_direct;
    case (led_function)
      LED_DIRECTLY_FROM_DSP: led_next = led_direct;
      LED_FROM_COUNT_CLK:    led_next = cnt_all[0][HB_BIT -: LED_WIDTH];
      LED_FROM_CH1:          led_next = cnt_all[1][LED_WIDTH-1:0];
      default: begin
        led_next    = '1;
        led_next[0] = cnt_all[0][HB_BIT];
      end
    endcase
  end

  // registered LED drive
  always_ff @(posedge xclk or posedge reset) begin
    if (reset) begin
      led_out <= LED_WIDTH'(1);
    end else begin
      led_out <= led_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a 4x32-bit instance for bus, event, shadow and
// LED behaviour, and two 16-bit instances (wrap and saturate) with a nonzero
// address offset whose clock channels run long enough to overflow.
module tb_perf_counter_bank;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int LW  = 2;
  localparam int HB  = 5;

  // ---------------- clock / reset ----------------
  logic xclk  = 1'b0;
  logic reset = 1'b1;
  always #5 xclk = ~xclk;

  // ---------------- main instance ----------------
  logic           wq = 1'b0, rq = 1'b0;
  logic [7:0]     ab = 8'h00;
  logic [15:0]    db_in = 16'h0000;
  logic [NCH-1:0] event_in = '0;
  logic [15:0]    db_out;
  logic           data_avail;
  logic [LW-1:0]  led_out;

  perf_counter_bank #(
    .NUM_CH(NCH), .CNT_WIDTH(CW), .LED_WIDTH(LW), .HB_BIT(HB), .offset_to_add_to_ab(0)
  ) dut (
    .xclk(xclk), .reset(reset), .write_qualified(wq), .read_qualified(rq),
    .ab(ab), .db_in(db_in), .event_in(event_in),
    .db_out(db_out), .data_avail(data_avail), .led_out(led_out)
  );

  // ---------------- 16-bit pair (offset 0x40) ----------------
  logic        wq16 = 1'b0, rq16 = 1'b0;
  logic [7:0]  ab16 = 8'h00;
  logic [15:0] d16w = 16'h0000, d16s = 16'h0000;
  logic [15:0] dbw, dbs;
  logic        avw, avs;
  logic [0:0]  ledw, leds;

  perf_counter_bank #(
    .NUM_CH(2), .CNT_WIDTH(16), .LED_WIDTH(1), .HB_BIT(4), .offset_to_add_to_ab(8'h40)
  ) dut_wrap (
    .xclk(xclk), .reset(reset), .write_qualified(wq16), .read_qualified(rq16),
    .ab(ab16), .db_in(d16w), .event_in(2'b00),
    .db_out(dbw), .data_avail(avw), .led_out(ledw)
  );

  perf_counter_bank #(
    .NUM_CH(2), .CNT_WIDTH(16), .LED_WIDTH(1), .HB_BIT(4), .offset_to_add_to_ab(8'h40)
  ) dut_sat (
    .xclk(xclk), .reset(reset), .write_qualified(wq16), .read_qualified(rq16),
    .ab(ab16), .db_in(d16s), .event_in(2'b00),
    .db_out(dbs), .data_avail(avs), .led_out(leds)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [CW-1:0]  m_cnt [NCH];
  logic [CW-1:0]  m_shd [NCH];
  logic [3:0]     m_hist [NCH];   // event samples: bit0 = this edge, bit3 = three edges ago
  logic [NCH-1:0] m_en = '1;
  logic           m_sat = 1'b0;
  logic [1:0]     m_ledf = 2'b11;
  logic [LW-1:0]  m_ledd = 2'b01;
  logic [NCH-1:0] m_clear = '0;
  logic           m_ctrl_wr = 1'b0;
  logic [NCH-1:0] m_ctrl_val = '0;
  int unsigned    n16 = 0;        // clock edges since reset release

  always @(posedge xclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = '0; m_shd[c] = '0; m_hist[c] = '0;
      end
      m_en = '1; m_sat = 1'b0; m_ledf = 2'b11; m_ledd = 2'b01; n16 = 0;
    end else begin
      n16++;
      for (int c = 0; c < NCH; c++) begin
        m_hist[c] = {m_hist[c][2:0], event_in[c]};
        // an edge becomes a count three clocks after the input is first sampled high
        if (m_clear[c]) m_cnt[c] = '0;
        else if (m_en[c] && (c == 0 || (m_hist[c][2] && !m_hist[c][3]))) m_cnt[c] = m_cnt[c] + 1;
      end
      if (m_ctrl_wr) m_en = m_ctrl_val;
    end
  end

  function automatic void model_read(input logic [7:0] a, output logic [15:0] d, output logic av);
    int off, c, w;
    off = int'(a) - 32;
    d = 16'hFFFF; av = 1'b0;
    if (a == 8'h05) begin
      d = {m_sat, {(15 - NCH){1'b0}}, m_en}; av = 1'b1;
    end else if (a == 8'h06) begin
      d = 16'h0000; av = 1'b1;   // 32-bit counters cannot wrap within this run
    end else if (off >= 0 && off < 4 * NCH && (off % 4) < CW / 16) begin
      c = off / 4; w = off % 4; av = 1'b1;
      if (w == 0) begin
        d = m_cnt[c][15:0];
        m_shd[c] = m_cnt[c];
      end else begin
        d = m_shd[c][16*w +: 16];
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge xclk);
    ab = a; db_in = d; wq = 1'b1;
    if (a == 8'h01) m_clear = d[NCH-1:0];
    if (a == 8'h00) begin m_ctrl_wr = 1'b1; m_ctrl_val = d[NCH-1:0]; m_sat = d[15]; end
    if (a == 8'h03) m_ledf = d[1:0];
    if (a == 8'h04) m_ledd = d[LW-1:0];
    @(negedge xclk);
    m_clear = '0; m_ctrl_wr = 1'b0;
    @(negedge xclk);            // strobe held a second cycle: still one access
    wq = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input int hold, input string tag);
    logic [15:0] ed;
    logic ea;
    @(negedge xclk);
    ab = a; rq = 1'b1;
    model_read(a, ed, ea);
    exp_q.push_back(ed);
    @(posedge xclk); #1;
    ed = exp_q.pop_front();
    check({tag, ".data"}, 32'(db_out), 32'(ed));
    check({tag, ".avail"}, 32'(data_avail), 32'(ea));
    @(negedge xclk);
    ab = 8'h7F;                 // address moves while strobe held: no new access
    for (int i = 1; i < hold; i++) begin
      @(posedge xclk); #1;
      check({tag, ".hold"}, 32'(db_out), 32'(ed));
    end
    @(negedge xclk);
    rq = 1'b0;
    @(posedge xclk); #1;
    check({tag, ".drop"}, 32'(data_avail), 32'd0);
    check({tag, ".keep"}, 32'(db_out), 32'(ed));
  endtask

  task automatic pulse(input int ch, input int width);
    @(negedge xclk);
    event_in[ch] = 1'b1;
    repeat (width) @(negedge xclk);
    event_in[ch] = 1'b0;
    repeat (4) @(negedge xclk);
  endtask

  task automatic led_chk(input string tag);
    logic [LW-1:0] e;
    @(negedge xclk);
    case (m_ledf)
      2'b00:   e = m_ledd;
      2'b01:   e = m_cnt[0][HB -: LW];
      2'b10:   e = m_cnt[1][LW-1:0];
      default: e = {1'b1, m_cnt[0][HB]};
    endcase
    @(posedge xclk); #1;
    check(tag, 32'(led_out), 32'(e));
  endtask

  task automatic w16(input logic [7:0] a, input logic [15:0] dw, input logic [15:0] ds);
    @(negedge xclk);
    ab16 = a; d16w = dw; d16s = ds; wq16 = 1'b1;
    @(negedge xclk);
    wq16 = 1'b0;
  endtask

  task automatic r16(input logic [7:0] a, output int unsigned n,
                     output logic [15:0] gw, output logic gaw,
                     output logic [15:0] gs, output logic gas);
    @(negedge xclk);
    ab16 = a; rq16 = 1'b1; n = n16;
    @(posedge xclk); #1;
    gw = dbw; gaw = avw; gs = dbs; gas = avs;
    @(negedge xclk);
    rq16 = 1'b0;
  endtask

  // ---------------- directed / randomized sequence ----------------
  initial begin
    int unsigned n;
    logic [15:0] gw, gs;
    logic gaw, gas;

    repeat (3) @(posedge xclk);
    #1;
    check("rst.db_out", 32'(db_out), 32'h0);
    check("rst.avail", 32'(data_avail), 32'h0);
    check("rst.led", 32'(led_out), 32'h1);
    check("rst16.db_out", 32'(dbs), 32'h0);
    @(negedge xclk) reset = 1'b0;

    // saturate-mode instance; the wrap instance keeps its reset CTRL value
    w16(8'h40, 16'h0003, 16'h8003);

    repeat (100) @(posedge xclk);
    rd(8'h20, 1, "ch0_lo");
    rd(8'h21, 1, "ch0_hi");
    rd(8'h05, 1, "ctrl_rst");
    led_chk("led_heartbeat_rst");

    // only ch0 enabled, clear it, then one long read = one shadow capture
    wr(8'h00, 16'h0001);
    wr(8'h01, 16'h0001);
    rd(8'h20, 5, "ch0_held");
    rd(8'h22, 1, "unmapped_w2");
    rd(8'h30, 1, "unmapped_ch4");
    rd(8'h7F, 1, "unmapped_7f");

    // event counting on ch1, then a pulse while ch1 is disabled
    wr(8'h00, 16'h000F);
    for (int k = 0; k < 3; k++) pulse(1, 3);
    rd(8'h24, 1, "ch1_three");
    wr(8'h00, 16'h000D);
    pulse(1, 3);
    rd(8'h24, 1, "ch1_disabled");
    wr(8'h00, 16'h000F);

    // CLEAR of ch1 on the very edge its pending event would count
    @(negedge xclk);
    event_in[1] = 1'b1;
    @(negedge xclk);
    wr(8'h01, 16'h0002);
    event_in[1] = 1'b0;
    repeat (4) @(negedge xclk);
    rd(8'h24, 1, "ch1_clear_vs_edge");

    // random event traffic under random enable masks, random read order
    for (int b = 0; b < 4; b++) begin
      wr(8'h00, {12'h000, 3'($urandom_range(0, 7)), 1'b1});
      repeat ($urandom_range(60, 120)) begin
        @(negedge xclk);
        event_in[NCH-1:1] = 3'($urandom);
      end
      @(negedge xclk);
      event_in = '0;
      repeat (5) @(negedge xclk);
      repeat (4) rd(8'(32 + 4 * $urandom_range(1, 3) + $urandom_range(0, 1)), 1, "rand_rd");
    end
    rd(8'h05, 1, "ctrl_rd");
    rd(8'h06, 1, "ovf_rd");

    // LED sources
    wr(8'h04, 16'h0002);
    wr(8'h03, 16'h0000);
    led_chk("led_direct");
    wr(8'h03, 16'h0001);
    repeat (4) begin
      repeat ($urandom_range(3, 20)) @(posedge xclk);
      led_chk("led_count_clk");
    end
    wr(8'h03, 16'h0002);
    led_chk("led_ch1");
    wr(8'h03, 16'h0003);
    repeat (3) begin
      repeat ($urandom_range(10, 40)) @(posedge xclk);
      led_chk("led_heartbeat");
    end

    // shadow coherence: capture now, read the high word after ch0 passes 2^16
    wr(8'h00, 16'h000F);
    rd(8'h20, 1, "ch0_capture");
    repeat (70000) @(posedge xclk);
    rd(8'h21, 1, "ch0_hi_stale");
    rd(8'h20, 1, "ch0_recapture");
    rd(8'h21, 1, "ch0_hi_live");

    // 16-bit pair: both clock channels have passed 2^16 increments
    r16(8'h60, n, gw, gaw, gs, gas);
    check("wrap16.cnt", 32'(gw), 32'(n % 65536));
    check("sat16.cnt", 32'(gs), (n >= 65535) ? 32'hFFFF : 32'(n));
    check("sat16.avail", 32'(gas), 32'h1);
    r16(8'h46, n, gw, gaw, gs, gas);
    check("wrap16.ovf", 32'(gw), (n >= 65536) ? 32'h1 : 32'h0);
    check("sat16.ovf", 32'(gs), (n >= 65536) ? 32'h1 : 32'h0);
    w16(8'h42, 16'h0001, 16'h0001);
    r16(8'h46, n, gw, gaw, gs, gas);
    check("wrap16.ovf_clr", 32'(gw), 32'h0);
    // saturated ch0 retries every cycle, so its set wins over the clear
    check("sat16.ovf_clr", 32'(gs), 32'h1);
    r16(8'h45, n, gw, gaw, gs, gas);
    check("wrap16.ctrl", 32'(gw), 32'h0003);
    check("sat16.ctrl", 32'(gs), 32'h8003);
    r16(8'h61, n, gw, gaw, gs, gas);
    check("w16_w1.data", 32'(gw), 32'hFFFF);
    check("w16_w1.avail", 32'(gaw), 32'h0);

    // reset in the middle of a held read
    @(negedge xclk);
    ab = 8'h20; rq = 1'b1;
    @(posedge xclk); #1;
    #2 reset = 1'b1;
    #1;
    check("midrst.led", 32'(led_out), 32'h1);
    check("midrst.avail", 32'(data_avail), 32'h0);
    check("midrst.db_out", 32'(db_out), 32'h0);
    @(negedge xclk) reset = 1'b0;
    repeat (3) begin
      @(posedge xclk); #1;
      check("midrst.no_access", 32'(data_avail), 32'h0);
    end
    @(negedge xclk) rq = 1'b0;
    repeat (20) @(posedge xclk);
    rd(8'h20, 1, "post_rst_ch0");
    rd(8'h05, 1, "post_rst_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
